// File: rtl/port_peripheral_if.sv
// port_peripheral_if
//
// Purpose: host-side streaming interface of port_peripheral. It bundles the
// TX stream (host -> CPU), the RX stream (CPU -> host) and the sticky RX
// overflow flag.
//
// Handshake: a beat transfers on a rising clock edge where VALID and READY are
// both 1. VALID never depends on READY. A source holding VALID keeps its data
// stable until the beat transfers. READY may be asserted or withdrawn at any
// time.
//
// Signals:
//   TX_DATA  [DWIDTH] host byte offered to the CPU
//   TX_VALID          TX_DATA is valid
//   TX_READY          TX FIFO can accept a byte
//   RX_DATA  [DWIDTH] head of the RX FIFO (0 when empty)
//   RX_VALID          RX FIFO holds at least one byte
//   RX_READY          host accepts RX_DATA
//   RX_OVF            sticky: a CPU write was dropped because RX was full
//
// Modports: master = host side, slave = port_peripheral.
interface port_peripheral_if #(
   parameter int DWIDTH = 8
);
   logic [DWIDTH-1:0] TX_DATA;
   logic              TX_VALID;
   logic              TX_READY;
   logic [DWIDTH-1:0] RX_DATA;
   logic              RX_VALID;
   logic              RX_READY;
   logic              RX_OVF;

   modport master (
      output TX_DATA, TX_VALID, RX_READY,
      input  TX_READY, RX_DATA, RX_VALID, RX_OVF
   );

   modport slave (
      input  TX_DATA, TX_VALID, RX_READY,
      output TX_READY, RX_DATA, RX_VALID, RX_OVF
   );
endinterface

// File: rtl/port_peripheral.sv
// port_peripheral
//
// Purpose: device-side endpoint of the CPU's bidirectional PORT bus. A TX FIFO
// (host -> CPU) supplies the byte the CPU reads; an RX FIFO (CPU -> host)
// captures the byte the CPU writes. The host talks to both FIFOs through
// valid/ready streams in port_peripheral_if.
//
// Ports:
//   CLK      clock, all state changes on the rising edge
//   RST      synchronous, active-high reset (flushes both FIFOs)
//   PORT     [DWIDTH] inout CPU port bus, driven only during a CPU read
//   PORT_RD  CPU samples PORT this cycle
//   PORT_WR  CPU drives PORT this cycle (wins over PORT_RD)
//   host     port_peripheral_if.slave: TX/RX streams and RX_OVF
//
// Build option: PORT_STATUS_EN. When defined, a CPU read of an empty TX FIFO
// returns a status byte {1, RX_OVF, rx_full, 1, rx_count (saturated at 15)}
// and clears RX_OVF. When undefined such a read returns 0 and RX_OVF clears
// only on reset.
module port_peripheral #(
   parameter int DWIDTH = 8,
   parameter int DEPTH  = 4,
   parameter int AWIDTH = 2
) (
   input  logic              CLK,
   input  logic              RST,
   inout  wire  [DWIDTH-1:0] PORT,
   input  logic              PORT_RD,
   input  logic              PORT_WR,
   port_peripheral_if.slave  host
);

   localparam logic [AWIDTH:0]   CNT_FULL = (AWIDTH+1)'(DEPTH);
   localparam logic [AWIDTH:0]   CNT_ONE  = (AWIDTH+1)'(1);
   localparam logic [AWIDTH-1:0] PTR_ONE  = AWIDTH'(1);

   logic [DWIDTH-1:0] tx_mem [DEPTH];
   logic [DWIDTH-1:0] rx_mem [DEPTH];
   logic [AWIDTH-1:0] tx_wr_ptr, tx_rd_ptr;
   logic [AWIDTH-1:0] rx_wr_ptr, rx_rd_ptr;
   logic [AWIDTH:0]   tx_count, rx_count;
   logic              rx_ovf;

   logic              tx_empty, rx_empty, rx_full;
   logic              cpu_rd, tx_push, tx_pop, rx_push, rx_pop;
   logic              ovf_set, status_rd;
   logic [DWIDTH-1:0] empty_byte;
   logic [DWIDTH-1:0] port_out;

   assign tx_empty = (tx_count == '0);
   assign rx_empty = (rx_count == '0);
   assign rx_full  = (rx_count == CNT_FULL);

   // A simultaneous read and write is treated purely as a write.
   assign cpu_rd   = PORT_RD && !PORT_WR;

   assign host.TX_READY = !RST && (tx_count != CNT_FULL);
   assign host.RX_VALID = !rx_empty;
   assign host.RX_DATA  = rx_empty ? '0 : rx_mem[rx_rd_ptr];
   assign host.RX_OVF   = rx_ovf;

   // TX push/pop decisions use the registered count, so a pop from a full
   // FIFO does not open TX_READY in the same cycle, and a push into an empty
   // FIFO is not visible to a read in the same cycle.
   assign tx_push  = host.TX_VALID && host.TX_READY;
   assign tx_pop   = !RST && cpu_rd && !tx_empty;
   assign rx_pop   = !RST && host.RX_VALID && host.RX_READY;
   // A host pop frees a slot in the same edge, so a write into a full FIFO
   // still lands when the host is draining.
   assign rx_push  = !RST && PORT_WR && (!rx_full || rx_pop);
   assign ovf_set  = !RST && PORT_WR && rx_full && !rx_pop;

`ifdef PORT_STATUS_EN
   logic [3:0] rx_count_sat;

   always_comb begin
      rx_count_sat = 4'hF;
      if (32'(rx_count) <= 32'd15) rx_count_sat = 4'(rx_count);
   end

   assign empty_byte = DWIDTH'({1'b1, rx_ovf, rx_full, 1'b1, rx_count_sat});
   assign status_rd  = !RST && cpu_rd && tx_empty;
`else
   assign empty_byte = '0;
   assign status_rd  = 1'b0;
`endif

   assign port_out = tx_empty ? empty_byte : tx_mem[tx_rd_ptr];
   assign PORT     = (cpu_rd && !RST) ? port_out : {DWIDTH{1'bz}};

   // FIFO storage carries no reset; pointers and counts define validity.
   always_ff @(posedge CLK) begin
      if (tx_push) tx_mem[tx_wr_ptr] <= host.TX_DATA;
      if (rx_push) rx_mem[rx_wr_ptr] <= PORT;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         tx_wr_ptr <= '0;
         tx_rd_ptr <= '0;
         tx_count  <= '0;
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         rx_count  <= '0;
         rx_ovf    <= 1'b0;
      end else begin
         if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
         if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
         case ({tx_push, tx_pop})
            2'b10:   tx_count <= tx_count + CNT_ONE;
            2'b01:   tx_count <= tx_count - CNT_ONE;
            default: tx_count <= tx_count;
         endcase

         if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
         if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
         case ({rx_push, rx_pop})
            2'b10:   rx_count <= rx_count + CNT_ONE;
            2'b01:   rx_count <= rx_count - CNT_ONE;
            default: rx_count <= rx_count;
         endcase

         // A new overflow beats a status read in the same cycle.
         if (ovf_set)        rx_ovf <= 1'b1;
         else if (status_rd) rx_ovf <= 1'b0;
      end
   end

endmodule

// File: tb/tb_port_peripheral.sv
module tb_port_peripheral;

   localparam int DEPTH = 4;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       PORT_RD = 1'b0;
   logic       PORT_WR = 1'b0;
   logic       tb_drv_en = 1'b0;
   logic [7:0] tb_drv = 8'h00;
   wire  [7:0] PORT;

   assign PORT = tb_drv_en ? tb_drv : 8'hzz;

   port_peripheral_if #(.DWIDTH(8)) host_if ();

   port_peripheral #(.DWIDTH(8), .DEPTH(DEPTH), .AWIDTH(2)) dut (
      .CLK     (CLK),
      .RST     (RST),
      .PORT    (PORT),
      .PORT_RD (PORT_RD),
      .PORT_WR (PORT_WR),
      .host    (host_if.slave)
   );

   always #5 CLK = ~CLK;

   // Reference model: two byte queues and the sticky overflow bit.
   logic [7:0] tx_q[$];
   logic [7:0] exp_q[$];
   logic       ovf_m = 1'b0;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] port_seen;
   logic [7:0] rx_seen;
   logic       ovf_seen;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp)
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      else
         n_pass++;
   endtask

   function automatic logic [7:0] empty_byte_m();
`ifdef PORT_STATUS_EN
      return {1'b1, ovf_m, (exp_q.size() == DEPTH), 1'b1, 4'(exp_q.size())};
`else
      return 8'h00;
`endif
   endfunction

   // One clock cycle: drive at negedge, check combinational outputs, then
   // advance the model at the rising edge.
   task automatic cycle(input bit rd, input bit wr, input logic [7:0] pd,
                        input bit tv, input logic [7:0] td, input bit rr);
      int  tsz, rsz;
      bit  cpu_rd, tx_rdy, do_txpop, do_txpush, do_rxpop, ovf_set, do_rxpush;
      logic [7:0] exp_port;
      @(negedge CLK);
      PORT_RD = rd;
      PORT_WR = wr;
      tb_drv_en = wr;
      tb_drv = pd;
      host_if.TX_VALID = tv;
      host_if.TX_DATA = td;
      host_if.RX_READY = rr;
      #1;
      tsz = tx_q.size();
      rsz = exp_q.size();
      cpu_rd    = rd && !wr;
      tx_rdy    = (tsz != DEPTH);
      do_txpop  = cpu_rd && (tsz != 0);
      do_txpush = tv && tx_rdy;
      do_rxpop  = (rsz != 0) && rr;
      ovf_set   = wr && (rsz == DEPTH) && !do_rxpop;
      do_rxpush = wr && !ovf_set;

      check("tx_ready", host_if.TX_READY, tx_rdy);
      check("rx_valid", host_if.RX_VALID, rsz != 0);
      check("rx_data", host_if.RX_DATA, (rsz != 0) ? exp_q[0] : 8'h00);
      check("rx_ovf", host_if.RX_OVF, ovf_m);
      if (cpu_rd) begin
         exp_port = (tsz != 0) ? tx_q[0] : empty_byte_m();
         check("port_rd", PORT, exp_port);
      end
      if (wr) check("port_wr_bus", PORT, pd);
      port_seen = PORT;
      rx_seen   = host_if.RX_DATA;
      ovf_seen  = host_if.RX_OVF;

      @(posedge CLK);
      if (do_txpop)  void'(tx_q.pop_front());
      if (do_txpush) tx_q.push_back(td);
      if (do_rxpop)  void'(exp_q.pop_front());
      if (do_rxpush) exp_q.push_back(pd);
`ifdef PORT_STATUS_EN
      if (cpu_rd && tsz == 0) ovf_m = 1'b0;
`endif
      if (ovf_set) ovf_m = 1'b1;
   endtask

   // Reset for n cycles. The CPU is reading and the bench drives 8'h00 on
   // PORT, so any DUT drive during reset would corrupt the observed bus.
   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         RST = 1'b1;
         PORT_RD = 1'b1;
         PORT_WR = 1'b0;
         tb_drv_en = 1'b1;
         tb_drv = 8'h00;
         host_if.TX_VALID = 1'b1;
         host_if.TX_DATA = 8'hEE;
         host_if.RX_READY = 1'b0;
         #1;
         check("rst_tx_ready", host_if.TX_READY, 1'b0);
         check("rst_port_z", PORT, 8'h00);
         @(posedge CLK);
         tx_q.delete();
         exp_q.delete();
         ovf_m = 1'b0;
         #1;
         check("rst_rx_valid", host_if.RX_VALID, 1'b0);
         check("rst_rx_data", host_if.RX_DATA, 8'h00);
         check("rst_rx_ovf", host_if.RX_OVF, 1'b0);
      end
      @(negedge CLK);
      RST = 1'b0;
      PORT_RD = 1'b0;
      tb_drv_en = 1'b0;
      host_if.TX_VALID = 1'b0;
   endtask

   task automatic idle();
      cycle(0, 0, 8'h00, 0, 8'h00, 0);
   endtask

   initial begin
      logic [7:0] empty_lit;
`ifdef PORT_STATUS_EN
      empty_lit = 8'h90;
`else
      empty_lit = 8'h00;
`endif
      host_if.TX_VALID = 1'b0;
      host_if.TX_DATA  = 8'h00;
      host_if.RX_READY = 1'b0;

      do_reset(2);
      idle();
      check("tx_ready_after_rst", host_if.TX_READY, 1'b1);

      // TX path: two pushes, two reads, then an empty read.
      cycle(0, 0, 8'h00, 1, 8'h11, 0);
      cycle(0, 0, 8'h00, 1, 8'h22, 0);
      cycle(1, 0, 8'h00, 0, 8'h00, 0);
      check("rd_first", port_seen, 8'h11);
      cycle(1, 0, 8'h00, 0, 8'h00, 0);
      check("rd_second", port_seen, 8'h22);
      cycle(1, 0, 8'h00, 0, 8'h00, 0);
      check("rd_empty", port_seen, empty_lit);

      // RX path: two writes held, then drained one at a time.
      cycle(0, 1, 8'hA5, 0, 8'h00, 0);
      cycle(0, 1, 8'h5A, 0, 8'h00, 0);
      idle();
      check("rx_head_a5", rx_seen, 8'hA5);
      cycle(0, 0, 8'h00, 0, 8'h00, 1);
      idle();
      check("rx_head_5a", rx_seen, 8'h5A);
      cycle(0, 0, 8'h00, 0, 8'h00, 1);

      // RX overflow: fill, drop 8'hFF, drain the original four.
      cycle(0, 1, 8'h10, 0, 8'h00, 0);
      cycle(0, 1, 8'h20, 0, 8'h00, 0);
      cycle(0, 1, 8'h30, 0, 8'h00, 0);
      cycle(0, 1, 8'h40, 0, 8'h00, 0);
      cycle(0, 1, 8'hFF, 0, 8'h00, 0);
      idle();
      check("ovf_set", ovf_seen, 1'b1);
      cycle(0, 0, 8'h00, 0, 8'h00, 1);
      check("drain0", rx_seen, 8'h10);
      cycle(0, 0, 8'h00, 0, 8'h00, 1);
      check("drain1", rx_seen, 8'h20);
      cycle(0, 0, 8'h00, 0, 8'h00, 1);
      check("drain2", rx_seen, 8'h30);
      cycle(0, 0, 8'h00, 0, 8'h00, 1);
      check("drain3", rx_seen, 8'h40);
      idle();
      check("drained_empty", host_if.RX_VALID, 1'b0);
      // Empty-TX read: with the status build this clears the flag.
      cycle(1, 0, 8'h00, 0, 8'h00, 0);
      idle();

      // Full RX + write + host pop in the same cycle: byte accepted.
      do_reset(1);
      cycle(0, 1, 8'h10, 0, 8'h00, 0);
      cycle(0, 1, 8'h20, 0, 8'h00, 0);
      cycle(0, 1, 8'h30, 0, 8'h00, 0);
      cycle(0, 1, 8'h40, 0, 8'h00, 0);
      cycle(0, 1, 8'hFF, 0, 8'h00, 1);
      idle();
      check("no_ovf_with_pop", ovf_seen, 1'b0);
      cycle(0, 0, 8'h00, 0, 8'h00, 1);
      cycle(0, 0, 8'h00, 0, 8'h00, 1);
      cycle(0, 0, 8'h00, 0, 8'h00, 1);
      check("rx_third", rx_seen, 8'h40);
      cycle(0, 0, 8'h00, 0, 8'h00, 1);
      check("rx_ff_kept", rx_seen, 8'hFF);

      // Read and write together: the write wins.
      cycle(0, 0, 8'h00, 1, 8'h77, 0);
      cycle(1, 1, 8'h3C, 0, 8'h00, 0);
      check("rdwr_bus", port_seen, 8'h3C);
      idle();
      check("rdwr_rx", rx_seen, 8'h3C);
      cycle(1, 0, 8'h00, 0, 8'h00, 1);
      check("rdwr_tx_kept", port_seen, 8'h77);

      // Reset with both FIFOs half full.
      cycle(0, 0, 8'h00, 1, 8'hB1, 0);
      cycle(0, 1, 8'hC1, 1, 8'hB2, 0);
      cycle(0, 1, 8'hC2, 0, 8'h00, 0);
      do_reset(1);
      cycle(1, 0, 8'h00, 0, 8'h00, 0);
      check("post_rst_rd", port_seen, empty_lit);
      check("post_rst_tx_ready", host_if.TX_READY, 1'b1);

      // Randomized traffic against the queue model.
      for (int i = 0; i < 600; i++) begin
         cycle($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
               8'($urandom_range(0, 255)), $urandom_range(0, 1) == 1,
               8'($urandom_range(0, 255)), $urandom_range(0, 2) == 0);
         if (i == 300) do_reset(1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
